// File: rtl/ads131_frame_buffer_pkg.sv
// ads131_buf_pkg: shared derivations, policy constants and reader states for the ADS131 frame buffer.
// ADS131_FRAME_TIMESTAMP_EN adds one timestamp word per frame.
package ads131_buf_pkg;
    typedef enum logic {IDLE, MID_FRAME} rd_state_t;
    localparam int POLICY_DROP = 0;
    localparam int POLICY_OVERWRITE = 1;
`ifdef ADS131_FRAME_TIMESTAMP_EN
    localparam int TS_WORDS = 1;
`else
    localparam int TS_WORDS = 0;
`endif
    function automatic int ch_w(input int num_ch);
        return $clog2(num_ch + 1);
    endfunction
    function automatic int wpf(input int num_ch);
        return num_ch + TS_WORDS;
    endfunction
endpackage

// File: rtl/ads131_frame_buffer_if.sv
// ads131_frame_buffer_if: writer/reader bus of the ADS131 frame buffer.
interface ads131_frame_buffer_if
    import ads131_buf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam int FW   = $clog2(DEPTH) + 1;
    logic                     clear;
    logic                     in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     rd_req;
    logic                     rd_valid;
    logic [DATA_W-1:0]        rd_data;
    logic [CH_W-1:0]          rd_ch;
    logic                     rd_last;
    logic [FW-1:0]            frame_count;
    logic                     empty;
    logic                     full;
    logic [CNT_W-1:0]         overflow_count;
    modport master (
        output clear, in_valid, in_data, rd_req,
        input  rd_valid, rd_data, rd_ch, rd_last, frame_count, empty, full, overflow_count
    );
    modport slave (
        input  clear, in_valid, in_data, rd_req,
        output rd_valid, rd_data, rd_ch, rd_last, frame_count, empty, full, overflow_count
    );
endinterface

// File: rtl/ads131_buf_ram.sv
// ads131_buf_ram: dual-port frame store, whole frame written per cycle, one word read per cycle (registered).
module ads131_buf_ram #(
    parameter int DEPTH  = 16,
    parameter int WPF    = 4,
    parameter int DATA_W = 24,
    parameter int CH_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(DEPTH)-1:0] wa,
    input  logic [WPF*DATA_W-1:0]   wd,
    input  logic                    re,
    input  logic [$clog2(DEPTH)-1:0] ra,
    input  logic [CH_W-1:0]         rc,
    output logic [DATA_W-1:0]       q
);
    localparam int MW = $clog2(DEPTH * WPF);
    logic [DATA_W-1:0] mem [DEPTH*WPF];
    logic [MW-1:0] wbase, raddr;
    always_comb begin
        wbase = MW'(wa) * MW'(WPF);
        raddr = MW'(ra) * MW'(WPF) + MW'(rc);
    end
    // Each channel lands at frame*WPF + ch; a collision with the read returns the old word.
    always_ff @(posedge clk) begin
        if (we)
            for (int k = 0; k < WPF; k++)
                mem[wbase + MW'(k)] <= wd[k*DATA_W +: DATA_W];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (re)
            q <= mem[raddr];
    end
endmodule

// File: rtl/ads131_frame_buffer.sv
// ads131_frame_buffer: frame-aligned multi-channel sample buffer with overflow policy and counters.
// ADS131_FRAME_TIMESTAMP_EN appends a cycle-count word to every stored frame.
module ads131_frame_buffer
    import ads131_buf_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 24,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    parameter int CNT_W     = 16
) (
    input logic system_clock,
    input logic reset,
    ads131_frame_buffer_if.slave bus
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam int WPF  = wpf(NUM_CH);
    localparam int AW   = $clog2(DEPTH);
    localparam int FW   = AW + 1;
    localparam bit OVW  = OVERWRITE == POLICY_OVERWRITE;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0] count, count_n;
    logic [CH_W-1:0] idx;
    logic [CNT_W-1:0] ovf;
    rd_state_t state, state_n;
    logic rd_ok, last, is_full, wr_try, ovw, wr_en, lost;
    logic [WPF*DATA_W-1:0] wd;
`ifdef ADS131_FRAME_TIMESTAMP_EN
    logic [DATA_W-1:0] ts;
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset)
            ts <= '0;
        else
            ts <= ts + 1'b1;
    end
    assign wd = {ts, bus.in_data};
`else
    assign wd = bus.in_data;
`endif
    always_comb begin
        is_full = count == FW'(DEPTH);
        rd_ok   = bus.rd_req && count != '0 && !bus.clear;
        last    = rd_ok && idx == CH_W'(WPF - 1);
        wr_try  = bus.in_valid && !bus.clear;
        // Overwrite only while no frame is being read, so a partially read frame stays intact.
        ovw     = OVW && wr_try && is_full && !rd_ok && state == IDLE;
        wr_en   = wr_try && (!is_full || last || ovw);
        lost    = wr_try && is_full && !last;
        count_n = bus.clear ? '0 : count + FW'(wr_en && !ovw) - FW'(last);
        state_n = (bus.clear || last) ? IDLE : rd_ok ? MID_FRAME : state;
    end
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            idx          <= '0;
            ovf          <= '0;
            state        <= IDLE;
            bus.rd_valid <= 1'b0;
            bus.rd_ch    <= '0;
            bus.rd_last  <= 1'b0;
        end else begin
            wr_ptr       <= bus.clear ? '0 : wr_ptr + AW'(wr_en);
            rd_ptr       <= bus.clear ? '0 : rd_ptr + AW'(last || ovw);
            count        <= count_n;
            idx          <= (bus.clear || last) ? '0 : idx + CH_W'(rd_ok);
            ovf          <= bus.clear ? '0 : ovf + CNT_W'(lost && ovf != '1);
            state        <= state_n;
            bus.rd_valid <= rd_ok;
            bus.rd_ch    <= idx;
            bus.rd_last  <= last;
        end
    end
    assign bus.frame_count    = count;
    assign bus.empty          = count == '0;
    assign bus.full           = is_full;
    assign bus.overflow_count = ovf;
    ads131_buf_ram #(.DEPTH(DEPTH), .WPF(WPF), .DATA_W(DATA_W), .CH_W(CH_W)) u_ram (
        .clk(system_clock),
        .rst(reset),
        .we(wr_en),
        .wa(wr_ptr),
        .wd(wd),
        .re(rd_ok),
        .ra(rd_ptr),
        .rc(idx),
        .q(bus.rd_data)
    );
endmodule

// File: tb/tb_ads131_frame_buffer.sv
// tb_ads131_frame_buffer: directed bench driving a drop-policy and an overwrite-policy buffer with identical stimulus.
module tb_ads131_frame_buffer;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
`ifdef ADS131_FRAME_TIMESTAMP_EN
    localparam int WPF = NUM_CH + 1;
`else
    localparam int WPF = NUM_CH;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0, in_valid = 1'b0, rd_req = 1'b0;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    int n_chk = 0, n_fail = 0, cyc = 0;
    int ts_of [64];
    ads131_frame_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) a0 ();
    ads131_frame_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) a1 ();
    assign a0.clear = clear;
    assign a0.in_valid = in_valid;
    assign a0.in_data = in_data;
    assign a0.rd_req = rd_req;
    assign a1.clear = clear;
    assign a1.in_valid = in_valid;
    assign a1.in_data = in_data;
    assign a1.rd_req = rd_req;
    ads131_frame_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .OVERWRITE(0), .CNT_W(CNT_W)) d0 (
        .system_clock(clk), .reset(rst), .bus(a0));
    ads131_frame_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .OVERWRITE(1), .CNT_W(CNT_W)) d1 (
        .system_clock(clk), .reset(rst), .bus(a1));
    always #5 clk = ~clk;
    // Reference cycle count, matching the timestamp counter definition.
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] exp_word(input int id, input int k);
        return k == NUM_CH ? 32'(ts_of[id] & 24'hffffff) : 32'((id << 8) | k);
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_frame(input int id);
        in_valid = 1'b1;
        for (int k = 0; k < NUM_CH; k++) in_data[k*DATA_W +: DATA_W] = DATA_W'((id << 8) | k);
        ts_of[id] = cyc;
    endtask
    task automatic write_frames(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            set_frame(first + i);
            step();
        end
        in_valid = 1'b0;
    endtask
    task automatic check_word(input int w, input int b0, input int b1);
        int k;
        k = w % WPF;
        check("d0.rd_valid", 32'(a0.rd_valid), 1);
        check("d0.rd_data", 32'(a0.rd_data), exp_word(b0 + w / WPF, k));
        check("d0.rd_ch", 32'(a0.rd_ch), 32'(k));
        check("d0.rd_last", 32'(a0.rd_last), 32'(k == WPF - 1));
        check("d1.rd_valid", 32'(a1.rd_valid), 1);
        check("d1.rd_data", 32'(a1.rd_data), exp_word(b1 + w / WPF, k));
        check("d1.rd_ch", 32'(a1.rd_ch), 32'(k));
        check("d1.rd_last", 32'(a1.rd_last), 32'(k == WPF - 1));
    endtask
    task automatic read_words(input int n, input int w0, input int b0, input int b1);
        rd_req = 1'b1;
        for (int w = w0; w < w0 + n; w++) begin
            step();
            check_word(w, b0, b1);
        end
        rd_req = 1'b0;
    endtask
    task automatic check_both(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                              input logic [31:0] e0, input logic [31:0] e1);
        check({"d0.", tag}, o0, e0);
        check({"d1.", tag}, o1, e1);
    endtask
    initial begin
        int ids [4] = '{22, 23, 25, 26};
        step();
        step();
        rst = 1'b0;
        check_both("rd_valid_rst", 32'(a0.rd_valid), 32'(a1.rd_valid), 0, 0);
        check_both("rd_data_rst", 32'(a0.rd_data), 32'(a1.rd_data), 0, 0);
        check_both("rd_ch_rst", 32'(a0.rd_ch), 32'(a1.rd_ch), 0, 0);
        check_both("rd_last_rst", 32'(a0.rd_last), 32'(a1.rd_last), 0, 0);
        check_both("empty_rst", 32'(a0.empty), 32'(a1.empty), 1, 1);
        check_both("full_rst", 32'(a0.full), 32'(a1.full), 0, 0);
        check_both("ovf_rst", 32'(a0.overflow_count), 32'(a1.overflow_count), 0, 0);
        // Three frames then a continuous read burst
        write_frames(0, 3);
        check_both("fc_3", 32'(a0.frame_count), 32'(a1.frame_count), 3, 3);
        read_words(3 * WPF, 0, 0, 0);
        check_both("fc_drained", 32'(a0.frame_count), 32'(a1.frame_count), 0, 0);
        check_both("empty_drained", 32'(a0.empty), 32'(a1.empty), 1, 1);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check_both("rd_valid_empty_req", 32'(a0.rd_valid), 32'(a1.rd_valid), 0, 0);
        // Six frames into four slots, no reads: drop keeps 10..13, overwrite keeps 12..15
        write_frames(10, 6);
        check_both("full_6", 32'(a0.full), 32'(a1.full), 1, 1);
        check_both("fc_6", 32'(a0.frame_count), 32'(a1.frame_count), 4, 4);
        check_both("ovf_6", 32'(a0.overflow_count), 32'(a1.overflow_count), 2, 2);
        read_words(4 * WPF, 0, 10, 12);
        check_both("empty_6", 32'(a0.empty), 32'(a1.empty), 1, 1);
        // Full while mid-frame: new frame dropped under both policies
        write_frames(20, 4);
        read_words(2, 0, 20, 20);
        write_frames(24, 1);
        check_both("ovf_mid", 32'(a0.overflow_count), 32'(a1.overflow_count), 3, 3);
        check_both("fc_mid", 32'(a0.frame_count), 32'(a1.frame_count), 4, 4);
        read_words(WPF - 2, 2, 20, 20);
        check_both("fc_after_mid", 32'(a0.frame_count), 32'(a1.frame_count), 3, 3);
        // Full with a write in the same cycle as the final-word read
        write_frames(25, 1);
        check_both("full_25", 32'(a0.full), 32'(a1.full), 1, 1);
        read_words(WPF - 1, 0, 21, 21);
        rd_req = 1'b1;
        set_frame(26);
        step();
        rd_req = 1'b0;
        in_valid = 1'b0;
        check_word(WPF - 1, 21, 21);
        check_both("fc_wr_last", 32'(a0.frame_count), 32'(a1.frame_count), 4, 4);
        check_both("ovf_wr_last", 32'(a0.overflow_count), 32'(a1.overflow_count), 3, 3);
        foreach (ids[i]) read_words(WPF, 0, ids[i], ids[i]);
        check_both("empty_wr_last", 32'(a0.empty), 32'(a1.empty), 1, 1);
        // clear together with in_valid and rd_req
        write_frames(30, 2);
        read_words(1, 0, 30, 30);
        clear = 1'b1;
        rd_req = 1'b1;
        set_frame(32);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        check_both("rd_valid_clear", 32'(a0.rd_valid), 32'(a1.rd_valid), 0, 0);
        check_both("empty_clear", 32'(a0.empty), 32'(a1.empty), 1, 1);
        check_both("ovf_clear", 32'(a0.overflow_count), 32'(a1.overflow_count), 0, 0);
        step();
        rd_req = 1'b0;
        check_both("rd_valid_post_clear", 32'(a0.rd_valid), 32'(a1.rd_valid), 0, 0);
        // Reset asserted mid-frame
        write_frames(40, 5);
        check_both("ovf_pre_rst", 32'(a0.overflow_count), 32'(a1.overflow_count), 1, 1);
        read_words(1, 0, 40, 41);
        rst = 1'b1;
        #2;
        check_both("rd_valid_mid_rst", 32'(a0.rd_valid), 32'(a1.rd_valid), 0, 0);
        check_both("empty_mid_rst", 32'(a0.empty), 32'(a1.empty), 1, 1);
        check_both("ovf_mid_rst", 32'(a0.overflow_count), 32'(a1.overflow_count), 0, 0);
        check_both("rd_data_mid_rst", 32'(a0.rd_data), 32'(a1.rd_data), 0, 0);
        step();
        rst = 1'b0;
        write_frames(50, 1);
        read_words(WPF, 0, 50, 50);
        check_both("empty_end", 32'(a0.empty), 32'(a1.empty), 1, 1);
        step();
        check_both("rd_valid_end", 32'(a0.rd_valid), 32'(a1.rd_valid), 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ads131_frame_buffer.md
Name: ads131_frame_buffer

Overview:
- Parametrised multi-channel sample buffer between the ADS131A0x SPI master and the downstream reader (NIOS/DMA).
- Replaces the four independent per-channel dual-clock FIFOs with one frame-aligned store.
- Each input strobe writes one frame (all channels of one conversion). The reader drains frames word-by-word, with a channel tag and an end-of-frame marker.
- Adds configurable overflow policy, frame-occupancy reporting and a saturating overflow counter.

Parameters:
- NUM_CH, 4, ADC channels per frame (1..8).
- DATA_W, 24, bits per channel sample.
- DEPTH, 16, frame capacity; power of two, at least 2.
- OVERWRITE, 0, full policy: 0 = drop the new frame, 1 = discard the oldest frame.
- CNT_W, 16, width of overflow_count.

Ports:
- system_clock  in  1  single block clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush: empties the buffer and zeroes overflow_count.
- in_valid  in  1  one-cycle strobe; in_data holds a complete frame.
- in_data  in  NUM_CH*DATA_W  frame; channel k occupies bits [k*DATA_W +: DATA_W].
- rd_req  in  1  request the next word; honoured only when empty=0.
- rd_valid  out  1  rd_data/rd_ch/rd_last are valid this cycle.
- rd_data  out  DATA_W  sample word.
- rd_ch  out  CH_W  channel index of rd_data; CH_W = $clog2(NUM_CH+1).
- rd_last  out  1  rd_data is the final word of its frame.
- frame_count  out  $clog2(DEPTH)+1  complete frames stored, including a partially read frame.
- empty  out  1  frame_count==0.
- full  out  1  frame_count==DEPTH.
- overflow_count  out  CNT_W  number of frames lost; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high): pointers, channel index and all counters go to 0. Outputs: rd_valid=0, rd_data=0, rd_ch=0, rd_last=0, empty=1, full=0, overflow_count=0.
- Storage: DEPTH*WPF words, where WPF = NUM_CH words per frame. Address = frame_ptr*WPF + ch.
- Write: when in_valid=1 and not full, all NUM_CH words are stored in that cycle at wr_frame. wr_frame then advances modulo DEPTH and frame_count increments.
- Read: a rd_req accepted in cycle N gives rd_valid=1 in cycle N+1 (one-cycle latency).
  - rd_ch equals the read channel index at acceptance. The index then increments.
  - On the last word (index WPF-1), rd_last=1, the index wraps to 0, rd_frame advances and frame_count decrements.
  - rd_req while empty=1 is ignored and rd_valid=0 next cycle.
  - rd_req may be held high continuously: one word per cycle, with frames back-to-back.
- Reader state machine:
  - IDLE (index 0, nothing in flight) -> MID_FRAME on the first accepted word.
  - MID_FRAME -> IDLE on the accepted last word.
- Simultaneous write and final-word read: frame_count is unchanged; both pointers advance.
- Full with in_valid=1, OVERWRITE=0: the frame is dropped and overflow_count increments (saturating).
- Full with in_valid=1, OVERWRITE=1:
  - In IDLE: the new frame is written, rd_frame advances by one (oldest frame lost), frame_count stays DEPTH, and overflow_count increments.
  - In MID_FRAME: the frame being read is protected. The new frame is dropped and overflow_count increments.
- Full with in_valid=1 and a final-word read in the same cycle: the write is accepted and there is no overflow, under either policy.
- clear:
  - Has priority over in_valid and rd_req in the same cycle.
  - Next cycle: empty=1 and overflow_count=0.
  - An rd_valid already in flight still completes; nothing follows it.
- Pointer wrap: pointers are modulo DEPTH. frame_count is kept separately, so full and empty are never ambiguous.
- Reset asserted mid-frame: the partial read is abandoned; after release the block behaves as after power-up.

Optional Feature:
- Macro ADS131_FRAME_TIMESTAMP_EN.
- When defined:
  - A DATA_W free-running cycle counter (reset to 0, wraps) is sampled on every accepted in_valid.
  - The sample is stored as an extra word per frame, so WPF = NUM_CH+1.
  - The timestamp is read last, with rd_ch=NUM_CH and rd_last=1.
- When undefined: WPF = NUM_CH; there is no counter and rd_ch never equals NUM_CH.

Decomposition:
- Package ads131_buf_pkg holds:
  - the CH_W and WPF localparam derivations;
  - the policy constants POLICY_DROP=0 and POLICY_OVERWRITE=1;
  - the reader state enum {IDLE, MID_FRAME}.
- Sub-module ads131_buf_ram: simple dual-port RAM with registered read, DEPTH*WPF x DATA_W.
  - Write port: NUM_CH words written in parallel (banked per channel), plus the timestamp bank when enabled.

Test Plan:
- NUM_CH=4, DATA_W=24. Write frames F0..F2 with word = (frame<<8)|ch, then hold rd_req for 12 cycles -> 12 consecutive rd_valid words in order, rd_ch 0..3, rd_last on every 4th, frame_count 3->0, empty=1.
- DEPTH=4, OVERWRITE=0. Write 6 frames with no reads -> full=1, overflow_count=2; the reader sees frames 0..3.
- DEPTH=4, OVERWRITE=1. Write 6 frames in IDLE -> overflow_count=2; the reader sees frames 2..5.
- DEPTH=4, OVERWRITE=1, full, reader mid-frame. in_valid -> frame dropped, overflow_count+1, current frame read intact.
- Full buffer, in_valid in the same cycle as the last-word read -> frame_count stays 4, overflow_count unchanged.
- clear asserted together with in_valid, and reset asserted mid-frame -> empty=1, overflow_count=0, rd_valid=0 afterwards. With ADS131_FRAME_TIMESTAMP_EN defined: rd_ch=4 word equals the cycle count at in_valid.
